// File: rtl/axi4_b_rr_arbiter.sv
// Round-robin arbiter sharing one upstream AXI4 B channel among N_PORTS B sources.
// The winning beat is captured in a registered output slice, tagged with its source index.
module axi4_b_rr_arbiter #(
    parameter int  N_PORTS        = 4,
    parameter int  AXI_ID_WIDTH   = 4,
    parameter int  AXI_USER_WIDTH = 4,
    localparam int IDX_W          = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                                axi4_aclk,
    input  logic                                axi4_arst,
    input  logic [N_PORTS-1:0]                  port_en,
    input  logic [N_PORTS*AXI_ID_WIDTH-1:0]     m_axi4_bid,
    input  logic [N_PORTS*2-1:0]                m_axi4_bresp,
    input  logic [N_PORTS*AXI_USER_WIDTH-1:0]   m_axi4_buser,
    input  logic [N_PORTS-1:0]                  m_axi4_bvalid,
    output logic [N_PORTS-1:0]                  m_axi4_bready,
    output logic [AXI_ID_WIDTH-1:0]             s_axi4_bid,
    output logic [1:0]                          s_axi4_bresp,
    output logic [AXI_USER_WIDTH-1:0]           s_axi4_buser,
    output logic                                s_axi4_bvalid,
    input  logic                                s_axi4_bready,
    output logic [IDX_W-1:0]                    s_axi4_bsel
);

    logic [N_PORTS-1:0]        req_s;
    logic                      load_s;
    logic                      grant_s;
    logic                      found_s;
    logic [IDX_W-1:0]          winner_s;
    logic [IDX_W-1:0]          rr_next_s;
    logic [IDX_W-1:0]          rr_ptr_r;
    logic [AXI_ID_WIDTH-1:0]   sel_bid_s;
    logic [1:0]                sel_bresp_s;
    logic [AXI_USER_WIDTH-1:0] sel_buser_s;
    logic [AXI_ID_WIDTH-1:0]   bid_r;
    logic [1:0]                bresp_r;
    logic [AXI_USER_WIDTH-1:0] buser_r;
    logic                      bvalid_r;
    logic [IDX_W-1:0]          bsel_r;

    assign req_s   = m_axi4_bvalid & port_en;
    assign load_s  = ~bvalid_r | s_axi4_bready;
    // Reset forces every ready low even though the cleared slice would otherwise accept.
    assign grant_s = load_s & found_s & ~axi4_arst;

    // Winner search: ports at or above rr_ptr first, then wrap to the low ports.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (!found_s && req_s[p] && (p >= int'(rr_ptr_r))) begin
                found_s  = 1'b1;
                winner_s = IDX_W'(p);
            end else begin
                found_s  = found_s;
            end
        end
        for (int p = 0; p < N_PORTS; p++) begin
            if (!found_s && req_s[p]) begin
                found_s  = 1'b1;
                winner_s = IDX_W'(p);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Pointer successor, wrapping modulo N_PORTS.
    always_comb begin
        if (winner_s == IDX_W'(N_PORTS - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = winner_s + IDX_W'(1);
        end
    end

    // One-hot ready and the winner's payload mux.
    always_comb begin
        m_axi4_bready = '0;
        sel_bid_s     = '0;
        sel_bresp_s   = 2'b00;
        sel_buser_s   = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (winner_s == IDX_W'(p)) begin
                m_axi4_bready[p] = grant_s;
                sel_bid_s        = m_axi4_bid[p*AXI_ID_WIDTH +: AXI_ID_WIDTH];
                sel_bresp_s      = m_axi4_bresp[p*2 +: 2];
                sel_buser_s      = m_axi4_buser[p*AXI_USER_WIDTH +: AXI_USER_WIDTH];
            end else begin
                m_axi4_bready[p] = 1'b0;
            end
        end
    end

    // Output slice and round-robin pointer; everything holds while upstream stalls.
    always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
        if (axi4_arst) begin
            bvalid_r <= 1'b0;
            bid_r    <= '0;
            bresp_r  <= 2'b00;
            buser_r  <= '0;
            bsel_r   <= '0;
            rr_ptr_r <= '0;
        end else if (load_s) begin
            if (grant_s) begin
                bvalid_r <= 1'b1;
                bid_r    <= sel_bid_s;
                bresp_r  <= sel_bresp_s;
                buser_r  <= sel_buser_s;
                bsel_r   <= winner_s;
                rr_ptr_r <= rr_next_s;
            end else begin
                bvalid_r <= 1'b0;
            end
        end
    end

    assign s_axi4_bvalid = bvalid_r;
    assign s_axi4_bid    = bid_r;
    assign s_axi4_bresp  = bresp_r;
    assign s_axi4_buser  = buser_r;
    assign s_axi4_bsel   = bsel_r;

endmodule

// File: tb/tb_axi4_b_rr_arbiter.sv
// Bench for axi4_b_rr_arbiter: directed scenarios followed by random traffic,
// all compared against a transaction-level round-robin model.
module tb_axi4_b_rr_arbiter;

    localparam int N  = 4;
    localparam int IW = 4;
    localparam int UW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  port_en;
    logic [N*IW-1:0] m_bid;
    logic [N*2-1:0]  m_bresp;
    logic [N*UW-1:0] m_buser;
    logic [N-1:0]  m_bvalid;
    logic [N-1:0]  m_bready;
    logic [IW-1:0] s_bid;
    logic [1:0]    s_bresp;
    logic [UW-1:0] s_buser;
    logic          s_bvalid;
    logic          s_bready;
    logic [1:0]    s_bsel;

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit            e_valid;
    logic [IW-1:0] e_bid;
    logic [1:0]    e_bresp;
    logic [UW-1:0] e_buser;
    int            e_sel;
    int            m_ptr;
    bit            m_load;
    bit            m_grant;
    int            m_win;

    always #5 clk = ~clk;

    axi4_b_rr_arbiter #(.N_PORTS(N), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)) dut (
        .axi4_aclk     (clk),
        .axi4_arst     (rst),
        .port_en       (port_en),
        .m_axi4_bid    (m_bid),
        .m_axi4_bresp  (m_bresp),
        .m_axi4_buser  (m_buser),
        .m_axi4_bvalid (m_bvalid),
        .m_axi4_bready (m_bready),
        .s_axi4_bid    (s_bid),
        .s_axi4_bresp  (s_bresp),
        .s_axi4_buser  (s_buser),
        .s_axi4_bvalid (s_bvalid),
        .s_axi4_bready (s_bready),
        .s_axi4_bsel   (s_bsel)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_valid = 1'b0; e_bid = '0; e_bresp = 2'b00; e_buser = '0; e_sel = 0; m_ptr = 0;
    endtask

    // Which source the round-robin rule picks given the current inputs.
    task automatic model_comb();
        m_load  = !e_valid || s_bready;
        m_grant = 1'b0;
        m_win   = 0;
        if (m_load) begin
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_ptr + k) % N;
                if (!m_grant && m_bvalid[p] && port_en[p]) begin
                    m_grant = 1'b1;
                    m_win   = p;
                end
            end
        end
    endtask

    task automatic model_seq();
        if (m_load) begin
            if (m_grant) begin
                e_valid = 1'b1;
                e_bid   = m_bid[m_win*IW +: IW];
                e_bresp = m_bresp[m_win*2 +: 2];
                e_buser = m_buser[m_win*UW +: UW];
                e_sel   = m_win;
                m_ptr   = (m_win + 1) % N;
            end else begin
                e_valid = 1'b0;
            end
        end
    endtask

    // Checks outputs against the model mid-cycle, then advances one clock.
    task automatic cycle(input string tag);
        logic [31:0] exp_rdy;
        #1;
        model_comb();
        exp_rdy = m_grant ? (32'd1 << m_win) : 32'd0;
        check({tag, ".bready"}, 32'(m_bready), exp_rdy);
        check({tag, ".bvalid"}, 32'(s_bvalid), 32'(e_valid));
        check({tag, ".bid"},    32'(s_bid),    32'(e_bid));
        check({tag, ".bresp"},  32'(s_bresp),  32'(e_bresp));
        check({tag, ".buser"},  32'(s_buser),  32'(e_buser));
        check({tag, ".bsel"},   32'(s_bsel),   32'(e_sel));
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic set_beat(input int p, input logic [3:0] id, input logic [1:0] resp, input logic [3:0] user);
        m_bid[p*IW +: IW]  = id;
        m_bresp[p*2 +: 2]  = resp;
        m_buser[p*UW +: UW] = user;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; port_en = 4'hF; m_bvalid = 4'hF; s_bready = 1'b1;
        m_bid = '0; m_bresp = '0; m_buser = '0;
        model_reset();

        // reset state: ready held low even with every source valid
        @(posedge clk); @(posedge clk); #1;
        check("rst.bready", 32'(m_bready), 32'd0);
        check("rst.bvalid", 32'(s_bvalid), 32'd0);
        check("rst.bsel",   32'(s_bsel),   32'd0);
        check("rst.bid",    32'(s_bid),    32'd0);
        rst = 1'b0;
        m_bvalid = 4'b0000;
        cycle("idle");

        // single beat from port 2
        set_beat(2, 4'h5, 2'd2, 4'hA);
        m_bvalid = 4'b0100;
        #1;
        check("single.bready", 32'(m_bready), 32'h4);
        cycle("single");
        m_bvalid = 4'b0000;
        check("single.bvalid", 32'(s_bvalid), 32'd1);
        check("single.bid",    32'(s_bid),    32'h5);
        check("single.bresp",  32'(s_bresp),  32'd2);
        check("single.buser",  32'(s_buser),  32'hA);
        check("single.bsel",   32'(s_bsel),   32'd2);
        cycle("drain");

        // fairness from a fresh pointer
        do_reset();
        for (int p = 0; p < N; p++) set_beat(p, 4'(p + 8), 2'(p), 4'(15 - p));
        m_bvalid = 4'hF; port_en = 4'hF; s_bready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle("fair");
            check("fair.seq",   32'(s_bsel),   32'(i % N));
            check("fair.valid", 32'(s_bvalid), 32'd1);
        end

        // backpressure: register a port-0 beat, then stall with ports 1 and 3 pending
        m_bvalid = 4'b0001;
        cycle("bp.load");
        s_bready = 1'b0;
        m_bvalid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp.bready", 32'(m_bready), 32'd0);
            check("bp.hold",   32'(s_bsel),   32'd0);
            cycle("bp");
        end
        s_bready = 1'b1;
        #1;
        check("bp.release", 32'(m_bready), 32'h2);
        cycle("bp.rel");
        check("bp.next", 32'(s_bsel), 32'd1);

        // enable mask with the pointer sitting on the disabled port 2
        port_en = 4'b1011; m_bvalid = 4'b1100;
        #1;
        check("mask.first", 32'(m_bready), 32'h8);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mask.no2", 32'(m_bready[2]), 32'd0);
            cycle("mask");
        end
        port_en = 4'hF;
        #1;
        check("mask.en2", 32'(m_bready), 32'h4);
        cycle("mask.on");
        check("mask.sel2", 32'(s_bsel), 32'd2);

        // async reset during a stall
        m_bvalid = 4'hF; s_bready = 1'b0;
        cycle("stall");
        #3;
        rst = 1'b1;
        #1;
        check("arst.bvalid", 32'(s_bvalid), 32'd0);
        check("arst.bready", 32'(m_bready), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0; s_bready = 1'b1;
        #1;
        check("arst.ptr0", 32'(m_bready), 32'h1);
        cycle("arst.go");
        check("arst.sel0", 32'(s_bsel), 32'd0);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            port_en  = 4'($urandom_range(0, 15));
            m_bvalid = 4'($urandom_range(0, 15));
            m_bid    = 16'($urandom);
            m_bresp  = 8'($urandom);
            m_buser  = 16'($urandom);
            s_bready = ($urandom_range(0, 9) < 7);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
